// File: rtl/asym_flush_fifo_p_if.sv
`default_nettype none
// ============================================================================
// Module   : asym_flush_fifo_p_if
// Purpose  : Write/read/flush bundle for asym_flush_fifo_p. The optional level
//            signals exist only when ASYM_FIFO_LEVEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface asym_flush_fifo_p_if #(
   parameter int WR_W       = 4,
   parameter int RD_W       = 32,
   parameter int DEPTH_BITS = 128
);
   logic                                    wr_valid_i;
   logic [WR_W-1:0]                         wr_data_i;
   logic                                    rd_valid_i;
   logic [RD_W-1:0]                         rd_data_o;
   logic [$clog2(RD_W/WR_W+1)-1:0]          rd_units_o;
   logic                                    data_avail_o;
   logic                                    flush_i;
   logic                                    flush_done_o;
   logic                                    empty_o;
   logic                                    full_o;
`ifdef ASYM_FIFO_LEVEL_EN
   logic [$clog2(DEPTH_BITS/WR_W+1)-1:0]    level_o;
   logic                                    almost_full_o;
`endif

   modport master (
      output wr_valid_i, wr_data_i, rd_valid_i, flush_i,
      input  rd_data_o, rd_units_o, data_avail_o, flush_done_o, empty_o, full_o
`ifdef ASYM_FIFO_LEVEL_EN
      , input level_o, almost_full_o
`endif
   );

   modport slave (
      input  wr_valid_i, wr_data_i, rd_valid_i, flush_i,
      output rd_data_o, rd_units_o, data_avail_o, flush_done_o, empty_o, full_o
`ifdef ASYM_FIFO_LEVEL_EN
      , output level_o, almost_full_o
`endif
   );
endinterface
`default_nettype wire

// File: rtl/asym_flush_fifo_p.sv
`default_nettype none
// ============================================================================
// Module   : asym_flush_fifo_p
// Purpose  : Narrow-in / wide-out FIFO with a flush that drains a zero-padded
//            partial word. Optional macro ASYM_FIFO_LEVEL_EN adds level outputs.
// Revision : 1.0 - initial release
// ============================================================================
module asym_flush_fifo_p #(
   parameter int WR_W       = 4,
   parameter int RD_W       = 32,
   parameter int DEPTH_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   asym_flush_fifo_p_if.slave  bus
);
   localparam int R  = RD_W / WR_W;
   localparam int N  = DEPTH_BITS / WR_W;
   localparam int AW = $clog2(N);
   localparam int PW = AW + 1;
   localparam int UW = $clog2(R + 1);

   localparam logic [PW-1:0] R_P   = PW'(R);
   localparam logic [PW-1:0] N_P   = PW'(N);
   localparam logic [PW-1:0] ONE_P = PW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   marker;
   logic            flush_done;
   logic [WR_W-1:0] mem [N];

   logic            wr_fire;
   logic            rd_fire;
   logic            in_flush;
   logic [PW-1:0]   count;
   logic [PW-1:0]   avail;
   logic [PW-1:0]   take_p;
   logic [PW-1:0]   rd_ptr_nxt;
   logic [RD_W-1:0] rd_word;

   assign count    = wr_ptr - rd_ptr;
   assign in_flush = (state == FLUSH);
   assign wr_fire  = bus.wr_valid_i & ~bus.full_o;

   // During a flush only units written up to the request cycle are visible.
   assign avail      = in_flush ? (marker - rd_ptr) : count;
   assign take_p     = (in_flush && (avail < R_P)) ? avail : R_P;
   assign rd_fire    = bus.rd_valid_i & bus.data_avail_o;
   assign rd_ptr_nxt = rd_fire ? (rd_ptr + take_p) : rd_ptr;

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < R; k++) begin
         if (rd_fire && (PW'(k) < take_p))
            rd_word[k*WR_W +: WR_W] = mem[rd_ptr[AW-1:0] + AW'(k)];
      end
   end

   assign bus.rd_data_o    = rd_word;
   assign bus.rd_units_o   = rd_fire ? take_p[UW-1:0] : '0;
   assign bus.data_avail_o = (count >= R_P) | (in_flush & (avail != '0));
   assign bus.full_o       = (count == N_P);
   assign bus.empty_o      = (count == '0);
   assign bus.flush_done_o = flush_done;

`ifdef ASYM_FIFO_LEVEL_EN
   localparam int            CW   = $clog2(N + 1);
   localparam logic [PW-1:0] AF_P = PW'(N - R);

   assign bus.level_o       = CW'(count);
   assign bus.almost_full_o = (count >= AF_P);
`endif

   always_ff @(posedge clk) begin
      if (wr_fire)
         mem[wr_ptr[AW-1:0]] <= bus.wr_data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         marker     <= '0;
         state      <= IDLE;
         flush_done <= 1'b0;
      end else begin
         if (wr_fire)
            wr_ptr <= wr_ptr + ONE_P;
         rd_ptr     <= rd_ptr_nxt;
         flush_done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.flush_i) begin
                  marker <= wr_ptr + (wr_fire ? ONE_P : '0);
                  state  <= FLUSH;
               end
            end
            FLUSH: begin
               // Also covers an empty flush: rd_ptr already equals marker.
               if (rd_ptr_nxt == marker) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_asym_flush_fifo_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_asym_flush_fifo_p
// Purpose  : Directed self-checking bench for asym_flush_fifo_p (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_asym_flush_fifo_p;
   localparam int WR_W       = 4;
   localparam int RD_W       = 32;
   localparam int DEPTH_BITS = 128;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pulses;

   always #5 clk = ~clk;

   asym_flush_fifo_p_if #(.WR_W(WR_W), .RD_W(RD_W), .DEPTH_BITS(DEPTH_BITS)) bus_if ();

   asym_flush_fifo_p #(.WR_W(WR_W), .RD_W(RD_W), .DEPTH_BITS(DEPTH_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] d);
      bus_if.wr_valid_i = 1'b1;
      bus_if.wr_data_i  = d;
      step();
      bus_if.wr_valid_i = 1'b0;
   endtask

   task automatic get(input string tag, input logic [31:0] exp_d, input logic [31:0] exp_u);
      bus_if.rd_valid_i = 1'b1;
      @(negedge clk);
      chk({tag, "_data"}, bus_if.rd_data_o, exp_d);
      chk({tag, "_units"}, 32'(bus_if.rd_units_o), exp_u);
      step();
      bus_if.rd_valid_i = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_data"}, bus_if.rd_data_o, 32'h0);
      chk({tag, "_rd_units"}, 32'(bus_if.rd_units_o), 32'd0);
      chk({tag, "_avail"}, 32'(bus_if.data_avail_o), 32'd0);
      chk({tag, "_done"}, 32'(bus_if.flush_done_o), 32'd0);
      chk({tag, "_empty"}, 32'(bus_if.empty_o), 32'd1);
      chk({tag, "_full"}, 32'(bus_if.full_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus_if.wr_valid_i = 1'b0;
      bus_if.wr_data_i  = '0;
      bus_if.rd_valid_i = 1'b0;
      bus_if.flush_i    = 1'b0;

      #12;
      chk_reset_outputs("rst");
      step();
      rst = 1'b1;

      // One full word, packed low lane first
      for (int i = 1; i <= 8; i++) put(4'(i));
      @(negedge clk);
      chk("w8_avail", 32'(bus_if.data_avail_o), 32'd1);
      chk("w8_full", 32'(bus_if.full_o), 32'd0);
      step();
      get("w8", 32'h8765_4321, 32'd8);
      @(negedge clk);
      chk("w8_empty", 32'(bus_if.empty_o), 32'd1);
      chk("w8_avail_after", 32'(bus_if.data_avail_o), 32'd0);
      step();

      // Fill to capacity; a write while full must be dropped
      for (int i = 0; i < 32; i++) put(4'(i));
      @(negedge clk);
      chk("fill_full", 32'(bus_if.full_o), 32'd1);
      chk("fill_empty", 32'(bus_if.empty_o), 32'd0);
      step();
      put(4'h5);
      get("q0", 32'h7654_3210, 32'd8);
      get("q1", 32'hFEDC_BA98, 32'd8);
      get("q2", 32'h7654_3210, 32'd8);
      get("q3", 32'hFEDC_BA98, 32'd8);
      @(negedge clk);
      chk("q_empty", 32'(bus_if.empty_o), 32'd1);
      step();

      // Partial flush with a write in the request cycle, then writes in FLUSH
      put(4'hA);
      put(4'hB);
      put(4'hC);
      bus_if.flush_i = 1'b1;
      put(4'hD);
      bus_if.wr_valid_i = 1'b1;
      bus_if.wr_data_i  = 4'hE;
      @(negedge clk);
      chk("fl_avail", 32'(bus_if.data_avail_o), 32'd1);
      chk("fl_done_early", 32'(bus_if.flush_done_o), 32'd0);
      step();
      put(4'hF);
      get("fl", 32'h0000_DCBA, 32'd4);
      @(negedge clk);
      chk("fl_done", 32'(bus_if.flush_done_o), 32'd1);
      step();
      bus_if.flush_i = 1'b0;
      @(negedge clk);
      chk("fl_done_once", 32'(bus_if.flush_done_o), 32'd0);
      chk("fl_avail_after", 32'(bus_if.data_avail_o), 32'd0);
      step();
      for (int i = 1; i <= 6; i++) put(4'(i));
      get("post", 32'h6543_21FE, 32'd8);
      @(negedge clk);
      chk("post_empty", 32'(bus_if.empty_o), 32'd1);
      step();

      // Flush of exactly two full words: no padding, done after second read
      for (int i = 0; i < 16; i++) put(4'(i));
      bus_if.flush_i = 1'b1;
      step();
      get("af0", 32'h7654_3210, 32'd8);
      @(negedge clk);
      chk("af_done_mid", 32'(bus_if.flush_done_o), 32'd0);
      step();
      get("af1", 32'hFEDC_BA98, 32'd8);
      @(negedge clk);
      chk("af_done", 32'(bus_if.flush_done_o), 32'd1);
      step();
      bus_if.flush_i = 1'b0;
      @(negedge clk);
      chk("af_empty", 32'(bus_if.empty_o), 32'd1);
      step();

      // Flush of an empty FIFO completes without any read
      bus_if.flush_i = 1'b1;
      step();
      @(negedge clk);
      chk("ef_avail", 32'(bus_if.data_avail_o), 32'd0);
      chk("ef_done_early", 32'(bus_if.flush_done_o), 32'd0);
      step();
      @(negedge clk);
      chk("ef_done", 32'(bus_if.flush_done_o), 32'd1);
      step();
      bus_if.flush_i = 1'b0;

      // Reset in the middle of a flush aborts it silently
      put(4'h1);
      put(4'h2);
      put(4'h3);
      bus_if.flush_i = 1'b1;
      step();
      rst = 1'b0;
      bus_if.rd_valid_i = 1'b1;
      @(negedge clk);
      chk_reset_outputs("mrst");
      bus_if.flush_i    = 1'b0;
      bus_if.rd_valid_i = 1'b0;
      step();
      step();
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus_if.flush_done_o === 1'b1) pulses++;
         step();
      end
      chk("mrst_no_done", 32'(pulses), 32'd0);
      chk("mrst_empty", 32'(bus_if.empty_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
